axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Shares the single AXI read-address/read-data channel pair of the sram2axi bridge between the instruction-fetch SRAM port and the data SRAM port (reads only).
- Arbitrates AR issue, tracks one outstanding read per requester and routes R beats back by rid.
- Blocks data reads while the write path reports in-flight writes, which enforces read-after-write ordering.
- Sits between the CPU-side SRAM-like interfaces and the AXI master ports. The write channels are owned by a separate block.

Parameters:
- INST_ID, 4'd0, arid used for instruction reads
- DATA_ID, 4'd1, arid used for data reads

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  instruction read request
- inst_size  in  2  transfer size (log2 bytes)
- inst_addr  in  32  instruction read address
- inst_addr_ok  out  1  request accepted this cycle
- inst_data_ok  out  1  instruction read data valid (1-cycle pulse)
- inst_rdata  out  32  instruction read data
- data_req  in  1  data read request (write requests never reach this block)
- data_size  in  2  transfer size
- data_addr  in  32  data read address
- data_addr_ok  out  1  request accepted this cycle
- data_data_ok  out  1  data read data valid (1-cycle pulse)
- data_rdata  out  32  data read data
- wr_busy  in  1  write path has unacknowledged writes
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1  AXI AR
- arready  in  1  AXI AR
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI R
- rready  out  1  AXI R
- err_unexpected_r  out  1  sticky: R beat received with no matching outstanding ID

Behaviour:
- Reset values:
  - all outputs 0: arvalid, rready, both addr_ok, both data_ok, both rdata, err_unexpected_r, araddr, arsize.
  - arid = INST_ID.
  - outstanding flags inst_os and data_os cleared; FSM in IDLE.
- Constant AR fields: arlen = 0, arburst = 2'b01, arlock = 0, arcache = 0, arprot = 0.
- FSM states:
  - IDLE: eligibility is evaluated each cycle.
    - data eligible = data_req & ~data_os & ~wr_busy.
    - inst eligible = inst_req & ~inst_os.
    - Data has fixed priority over inst.
    - The winner's addr_ok is asserted combinationally in the same cycle. The loser's addr_ok stays 0.
    - At the clock edge: latch araddr, arsize = {1'b0, size} and arid of the winner; set the winner's outstanding flag; go to AR_WAIT.
  - AR_WAIT: arvalid = 1. AR fields are held stable until arready. On arvalid & arready go to IDLE.
- addr_ok is never asserted in AR_WAIT. Back-to-back issue is therefore at most one AR per 2 cycles.
- Outstanding tracking:
  - A flag is cleared on rvalid & rready & rlast with rid equal to that flag's ID.
  - A new grant to the same ID is possible no earlier than the cycle after the clear.
  - At most 2 reads are in flight (one per ID). Out-of-order return between the IDs is supported.
- rready = registered (inst_os | data_os), so it is high from the cycle after a grant until both flags are clear.
- Response routing:
  - On an R handshake with rid == INST_ID and inst_os set: inst_data_ok = 1 and inst_rdata = rdata in the following cycle, for exactly one cycle. The data side is analogous.
  - rdata outputs hold their value until the next return to the same port.
  - rresp is ignored (no error reporting).
- Unexpected beat: an R handshake whose rid matches no set flag sets err_unexpected_r (cleared only by reset). The beat is consumed and no data_ok is generated.
- Simultaneous events:
  - A grant in the same cycle as an R completion for the other ID: both take effect.
  - Both requesters eligible in IDLE: data wins; inst must hold its req.
  - wr_busy rising while a data read is already granted does not cancel it.
- Requester rule: req/addr/size stay stable until addr_ok. The block does not buffer unaccepted requests.
- Reset mid-operation: all state is cleared and arvalid drops. The AXI slave is reset concurrently; in-flight beats are discarded.

Test Plan:
- Single inst read, addr 0xBFC00000 size 2, arready after 3 cycles, rvalid 2 cycles later with rdata 0x3C1D0001 -> inst_addr_ok in cycle 0; arid 0, araddr 0xBFC00000, arsize 3'b010 held stable until arready; inst_data_ok pulse with inst_rdata 0x3C1D0001 one cycle after the R handshake.
- inst_req and data_req asserted together (data addr 0x80001000) -> data_addr_ok first with arid 1; inst_addr_ok on the first IDLE cycle after the data AR handshake.
- Both outstanding, slave returns rid 1 (0x11111111) then rid 0 (0x22222222) -> data_data_ok then inst_data_ok with the matching data; rready drops the cycle after the second clear.
- data_req held with wr_busy = 1 for 5 cycles -> no data_addr_ok and no AR during those cycles; grant on the first cycle wr_busy = 0; inst requests still granted meanwhile.
- R beat with rid 1 while data_os = 0 -> err_unexpected_r = 1 sticky; no data_data_ok.
- reset asserted during AR_WAIT -> next cycle arvalid = 0, both flags clear, all outputs at reset values; a fresh inst request is granted normally.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - AXI read-address / read-data channel bundle
interface axi_rd_arbiter_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - shares one AXI read channel between inst and data SRAM ports
module axi_rd_arbiter #(
   parameter logic [3:0] INST_ID = 4'd0,
   parameter logic [3:0] DATA_ID = 4'd1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   input  logic        wr_busy,
   axi_rd_arbiter_if.master axi,
   output logic        err_unexpected_r
);

   typedef enum logic {IDLE, AR_WAIT} state_t;

   state_t      state, state_n;
   logic        inst_os, data_os, inst_os_n, data_os_n;
   logic        inst_elig, data_elig;
   logic        r_hs, r_inst, r_data;
   logic        rready_q;
   logic [3:0]  arid_q;
   logic [31:0] araddr_q;
   logic [2:0]  arsize_q;
   logic [1:0]  rresp_unused;

   // Data reads wait for the write path to drain so they observe prior stores.
   assign data_elig = data_req & ~data_os & ~wr_busy;
   assign inst_elig = inst_req & ~inst_os;

   assign r_hs   = axi.rvalid & axi.rready;
   assign r_inst = r_hs & (axi.rid == INST_ID) & inst_os;
   assign r_data = r_hs & (axi.rid == DATA_ID) & data_os;

   assign inst_os_n = (inst_os & ~(r_inst & axi.rlast)) | inst_addr_ok;
   assign data_os_n = (data_os & ~(r_data & axi.rlast)) | data_addr_ok;

   always_comb begin
      state_n      = state;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      case (state)
         IDLE: begin
            if (!reset) begin
               if (data_elig) begin
                  data_addr_ok = 1'b1;
                  state_n      = AR_WAIT;
               end else if (inst_elig) begin
                  inst_addr_ok = 1'b1;
                  state_n      = AR_WAIT;
               end
            end
         end
         AR_WAIT: begin
            if (axi.arready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         inst_os          <= 1'b0;
         data_os          <= 1'b0;
         rready_q         <= 1'b0;
         arid_q           <= INST_ID;
         araddr_q         <= 32'd0;
         arsize_q         <= 3'd0;
         inst_data_ok     <= 1'b0;
         data_data_ok     <= 1'b0;
         inst_rdata       <= 32'd0;
         data_rdata       <= 32'd0;
         err_unexpected_r <= 1'b0;
      end else begin
         state    <= state_n;
         inst_os  <= inst_os_n;
         data_os  <= data_os_n;
         rready_q <= inst_os_n | data_os_n;
         if (data_addr_ok) begin
            arid_q   <= DATA_ID;
            araddr_q <= data_addr;
            arsize_q <= {1'b0, data_size};
         end else if (inst_addr_ok) begin
            arid_q   <= INST_ID;
            araddr_q <= inst_addr;
            arsize_q <= {1'b0, inst_size};
         end
         inst_data_ok <= r_inst;
         data_data_ok <= r_data;
         if (r_inst) inst_rdata <= axi.rdata;
         if (r_data) data_rdata <= axi.rdata;
         // A beat nobody is waiting for is still consumed so the slave never stalls.
         if (r_hs & ~r_inst & ~r_data) err_unexpected_r <= 1'b1;
      end
   end

   assign axi.arvalid = (state == AR_WAIT);
   assign axi.arid    = arid_q;
   assign axi.araddr  = araddr_q;
   assign axi.arsize  = arsize_q;
   assign axi.arlen   = 8'd0;
   assign axi.arburst = 2'b01;
   assign axi.arlock  = 2'b00;
   assign axi.arcache = 4'd0;
   assign axi.arprot  = 3'd0;
   assign axi.rready  = rready_q;
   assign rresp_unused = axi.rresp;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - scoreboard bench for axi_rd_arbiter
module tb_axi_rd_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        inst_req = 1'b0, data_req = 1'b0, wr_busy = 1'b0;
   logic [1:0]  inst_size = 2'd0, data_size = 2'd0;
   logic [31:0] inst_addr = 32'd0, data_addr = 32'd0;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, err_unexpected_r;
   logic [31:0] inst_rdata, data_rdata;

   axi_rd_arbiter_if axi();

   axi_rd_arbiter #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_size(data_size), .data_addr(data_addr),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .wr_busy(wr_busy), .axi(axi), .err_unexpected_r(err_unexpected_r)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic [38:0] exp_ar_q[$];
   logic [31:0] exp_inst_q[$];
   logic [31:0] exp_data_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flag_fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: got event expected none", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ar(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] size);
      exp_ar_q.push_back({id, addr, size});
   endtask

   // Monitor: AR fields must match the oldest expected grant on every arvalid cycle.
   always @(negedge clk) begin
      if (!reset) begin
         if (axi.arvalid) begin
            if (exp_ar_q.size() == 0) flag_fail("mon_ar_unexpected");
            else begin
               check("mon_ar_fields", {axi.arid, axi.araddr, axi.arsize}, exp_ar_q[0]);
               if (axi.arready) void'(exp_ar_q.pop_front());
            end
         end
         if (inst_data_ok) begin
            if (exp_inst_q.size() == 0) flag_fail("mon_inst_data_ok_unexpected");
            else check("mon_inst_rdata", inst_rdata, exp_inst_q.pop_front());
         end
         if (data_data_ok) begin
            if (exp_data_q.size() == 0) flag_fail("mon_data_data_ok_unexpected");
            else check("mon_data_rdata", data_rdata, exp_data_q.pop_front());
         end
      end
   end

   task automatic r_beat(input logic [3:0] id, input logic [31:0] d, input bit exp_i,
                         input bit exp_d, input bit exp_rr, input string tag);
      bit got;
      tick();
      axi.rid = id; axi.rdata = d; axi.rlast = 1'b1; axi.rresp = 2'b00; axi.rvalid = 1'b1;
      if (exp_i) exp_inst_q.push_back(d);
      if (exp_d) exp_data_q.push_back(d);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = axi.rready;
      end
      if (!got) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_rready_timeout: got rready 0 expected 1", tag);
         axi.rvalid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      axi.rvalid = 1'b0;
      @(negedge clk);
      check({tag, "_inst_data_ok"}, inst_data_ok, exp_i);
      check({tag, "_data_data_ok"}, data_data_ok, exp_d);
      check({tag, "_rready"}, axi.rready, exp_rr);
      @(negedge clk);
      check({tag, "_pulse_end"}, {inst_data_ok, data_data_ok}, 2'b00);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_arvalid"}, axi.arvalid, 0);
      check({tag, "_rready"}, axi.rready, 0);
      check({tag, "_err"}, err_unexpected_r, 0);
      check({tag, "_ar_fields"}, {axi.arid, axi.araddr, axi.arsize}, 39'd0);
      check({tag, "_rdata"}, {inst_rdata, data_rdata}, 64'd0);
      check({tag, "_data_ok"}, {inst_data_ok, data_data_ok}, 2'b00);
      check({tag, "_ar_const"}, {axi.arlen, axi.arburst, axi.arlock, axi.arcache, axi.arprot}, 19'h00200);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = 4'd0; axi.rdata = 32'd0;
      axi.rresp = 2'b00; axi.rlast = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_state("rst");

      // single inst read, arready after 3 cycles
      tick();
      inst_req = 1'b1; inst_addr = 32'hBFC00000; inst_size = 2'd2;
      push_ar(4'd0, 32'hBFC00000, 3'b010);
      @(negedge clk);
      check("t1_inst_addr_ok", inst_addr_ok, 1);
      check("t1_data_addr_ok", data_addr_ok, 0);
      check("t1_arvalid_idle", axi.arvalid, 0);
      tick(); inst_req = 1'b0;
      tick();
      tick(); axi.arready = 1'b1;
      tick(); axi.arready = 1'b0;
      @(negedge clk);
      check("t1_arvalid_after", axi.arvalid, 0);
      tick();
      r_beat(4'd0, 32'h3C1D0001, 1, 0, 0, "t1");
      check("t1_inst_rdata_hold", inst_rdata, 32'h3C1D0001);

      // simultaneous requests: data wins, inst holds
      tick();
      inst_req = 1'b1; inst_addr = 32'hBFC00004; inst_size = 2'd2;
      data_req = 1'b1; data_addr = 32'h80001000; data_size = 2'd2;
      push_ar(4'd1, 32'h80001000, 3'b010);
      push_ar(4'd0, 32'hBFC00004, 3'b010);
      @(negedge clk);
      check("t2_data_addr_ok", data_addr_ok, 1);
      check("t2_inst_addr_ok_lose", inst_addr_ok, 0);
      tick(); data_req = 1'b0; axi.arready = 1'b1;
      @(negedge clk);
      check("t2_inst_addr_ok_arwait", inst_addr_ok, 0);
      tick(); axi.arready = 1'b0;
      @(negedge clk);
      check("t2_inst_addr_ok", inst_addr_ok, 1);
      tick(); inst_req = 1'b0; axi.arready = 1'b1;
      tick(); axi.arready = 1'b0;

      // out-of-order return: data first, then inst
      r_beat(4'd1, 32'h11111111, 0, 1, 1, "t3d");
      r_beat(4'd0, 32'h22222222, 1, 0, 0, "t3i");
      check("t3_data_rdata_hold", data_rdata, 32'h11111111);

      // wr_busy blocks data for 5 cycles while inst is still served
      tick();
      wr_busy = 1'b1;
      data_req = 1'b1; data_addr = 32'h80002000; data_size = 2'd1;
      inst_req = 1'b1; inst_addr = 32'hBFC00008; inst_size = 2'd2;
      push_ar(4'd0, 32'hBFC00008, 3'b010);
      @(negedge clk);
      check("t4_inst_addr_ok", inst_addr_ok, 1);
      check("t4_data_blocked_c0", data_addr_ok, 0);
      tick(); inst_req = 1'b0; axi.arready = 1'b1;
      @(negedge clk);
      check("t4_data_blocked_c1", data_addr_ok, 0);
      tick(); axi.arready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t4_data_blocked", data_addr_ok, 0);
         check("t4_no_ar", axi.arvalid, 0);
         tick();
      end
      wr_busy = 1'b0;
      push_ar(4'd1, 32'h80002000, 3'b001);
      @(negedge clk);
      check("t4_data_addr_ok", data_addr_ok, 1);
      tick(); data_req = 1'b0; wr_busy = 1'b1;
      @(negedge clk);
      check("t4_ar_kept_busy", axi.arvalid, 1);
      tick(); axi.arready = 1'b1;
      tick(); axi.arready = 1'b0; wr_busy = 1'b0;
      r_beat(4'd0, 32'h33333333, 1, 0, 1, "t4i");
      r_beat(4'd1, 32'h44444444, 0, 1, 0, "t4d");

      // unexpected rid while only inst is outstanding
      @(negedge clk);
      check("t5_err_before", err_unexpected_r, 0);
      tick();
      inst_req = 1'b1; inst_addr = 32'hBFC0000C; inst_size = 2'd2;
      push_ar(4'd0, 32'hBFC0000C, 3'b010);
      @(negedge clk);
      check("t5_inst_addr_ok", inst_addr_ok, 1);
      tick(); inst_req = 1'b0; axi.arready = 1'b1;
      tick(); axi.arready = 1'b0;
      r_beat(4'd1, 32'h55555555, 0, 0, 1, "t5u");
      check("t5_err_set", err_unexpected_r, 1);
      r_beat(4'd0, 32'h66666666, 1, 0, 0, "t5i");
      check("t5_err_sticky", err_unexpected_r, 1);
      check("t5_data_rdata_untouched", data_rdata, 32'h44444444);

      // reset while in AR_WAIT, then a fresh read
      tick();
      inst_req = 1'b1; inst_addr = 32'hBFC00010; inst_size = 2'd2;
      push_ar(4'd0, 32'hBFC00010, 3'b010);
      @(negedge clk);
      check("t6_inst_addr_ok", inst_addr_ok, 1);
      tick(); inst_req = 1'b0;
      tick(); reset = 1'b1; exp_ar_q.delete();
      tick(); reset = 1'b0;
      @(negedge clk);
      check_reset_state("t6_rst");
      tick();
      inst_req = 1'b1; inst_addr = 32'hBFC00014; inst_size = 2'd2;
      push_ar(4'd0, 32'hBFC00014, 3'b010);
      @(negedge clk);
      check("t6_fresh_addr_ok", inst_addr_ok, 1);
      tick(); inst_req = 1'b0; axi.arready = 1'b1;
      tick(); axi.arready = 1'b0;
      r_beat(4'd0, 32'h77777777, 1, 0, 0, "t6i");

      repeat (2) tick();
      check("sb_ar_empty", exp_ar_q.size(), 0);
      check("sb_inst_empty", exp_inst_q.size(), 0);
      check("sb_data_empty", exp_data_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
